// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundle of the two requester ports and the shared data-memory
//             port handled by mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // master 0 (cpu data port)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [MASK_W-1:0] m0_mask;
  logic              m0_lock;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;

  // master 1 (loader / debug / DMA)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [MASK_W-1:0] m1_mask;
  logic              m1_lock;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;

  // shared memory port
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;

  // Arbiter view: takes requests and memory read data, drives acks and the memory port.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_lock,
    input  mem_do,
    output m0_ack, m0_rdata, m0_rvalid,
    output m1_ack, m1_rdata, m1_rvalid,
    output mem_a, mem_we, mem_mask, mem_di
  );

  // Requester/memory view: issues requests and supplies memory read data.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_lock,
    output mem_do,
    input  m0_ack, m0_rdata, m0_rvalid,
    input  m1_ack, m1_rdata, m1_rvalid,
    input  mem_a, mem_we, mem_mask, mem_di
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one data-memory port between two masters. Per-cycle
//             round-robin, optional bounded lock for atomic sequences, and
//             registered read return to the master that won the cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_LOCK + 1);
  // Count value on the last cycle a lock may be held.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // With a one-cycle lock limit the entry cycle is also the release cycle.
  localparam bit LOCK_ONE_SHOT = (MAX_LOCK == 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic              last_q,     last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              blk0_q,     blk0_d;
  logic              blk1_q,     blk1_d;
  logic [DATA_W-1:0] rdata0_q,   rdata0_d;
  logic [DATA_W-1:0] rdata1_q,   rdata1_d;
  logic              rvalid0_q,  rvalid0_d;
  logic              rvalid1_q,  rvalid1_d;

  logic              held;      // lock owner still asserting its lock
  logic              held_id;
  logic              gnt_vld;
  logic              gnt_id;
  logic              gnt_we;
  logic              gnt_lock;
  logic              gnt_blk;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [MASK_W-1:0] gnt_mask;

  // Pick this cycle's winner: a held lock excludes the other master, else round-robin.
  always_comb begin
    held    = 1'b0;
    held_id = 1'b0;
    if (state_q == ST_LOCK0 && bus.m0_lock) begin
      held    = 1'b1;
      held_id = 1'b0;
    end else if (state_q == ST_LOCK1 && bus.m1_lock) begin
      held    = 1'b1;
      held_id = 1'b1;
    end

    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (held) begin
      gnt_vld = held_id ? bus.m1_req : bus.m0_req;
      gnt_id  = held_id;
    end else if (bus.m0_req && bus.m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_q;
    end else if (bus.m0_req) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (bus.m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  // Select the winning master's request fields.
  always_comb begin
    gnt_we    = gnt_id ? bus.m1_we    : bus.m0_we;
    gnt_lock  = gnt_id ? bus.m1_lock  : bus.m0_lock;
    gnt_blk   = gnt_id ? blk1_q       : blk0_q;
    gnt_addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
    gnt_wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;
    gnt_mask  = gnt_id ? bus.m1_mask  : bus.m0_mask;
  end

  // Memory port and acks are combinational and read as zero with no winner.
  assign bus.mem_a    = gnt_vld ? gnt_addr  : '0;
  assign bus.mem_we   = gnt_vld & gnt_we;
  assign bus.mem_mask = gnt_vld ? gnt_mask  : '0;
  assign bus.mem_di   = gnt_vld ? gnt_wdata : '0;
  assign bus.m0_ack   = gnt_vld & ~gnt_id;
  assign bus.m1_ack   = gnt_vld &  gnt_id;

  assign bus.m0_rdata  = rdata0_q;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m1_rvalid = rvalid1_q;

  // Next state: lock entry/hold/forced release, round-robin pointer, read capture.
  always_comb begin
    state_d    = ST_ARB;
    last_d     = last_q;
    lock_cnt_d = '0;
    // A block is lifted on the first cycle its master lets go of lock.
    blk0_d     = blk0_q & bus.m0_lock;
    blk1_d     = blk1_q & bus.m1_lock;

    if (gnt_vld) begin
      last_d = gnt_id;
    end

    if (held) begin
      if (lock_cnt_q == LOCK_LAST) begin
        // Lock budget spent: hand the tie to the other master and bar relock.
        last_d = held_id;
        if (held_id) begin
          blk1_d = 1'b1;
        end else begin
          blk0_d = 1'b1;
        end
      end else begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q + CNT_ONE;
      end
    end else if (gnt_vld && gnt_lock && !gnt_blk) begin
      if (LOCK_ONE_SHOT) begin
        if (gnt_id) begin
          blk1_d = 1'b1;
        end else begin
          blk0_d = 1'b1;
        end
      end else begin
        state_d    = gnt_id ? ST_LOCK1 : ST_LOCK0;
        lock_cnt_d = CNT_ONE;
      end
    end

    rvalid0_d = gnt_vld & ~gnt_id & ~gnt_we;
    rvalid1_d = gnt_vld &  gnt_id & ~gnt_we;
    rdata0_d  = rvalid0_d ? bus.mem_do : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_do : rdata1_q;
  end

  // State and registered read-return outputs, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_ARB;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      blk0_q     <= 1'b0;
      blk1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      blk0_q     <= blk0_d;
      blk1_q     <= blk1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Randomized scoreboard bench for mem_port_arbiter with a
//             behavioural ownership model and a word-array memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // ---------------- memory behind the port (16 words) ----------------
  logic [31:0] mem [16];
  assign bus.mem_do = mem[bus.mem_a[5:2]];

  // Memory is preloaded with a fixed pattern while reset is high, written otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h9E37_79B9 * 32'(i + 1);
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_mask[b]) mem[bus.mem_a[5:2]][8*b +: 8] <= bus.mem_di[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } acc_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;

  acc_t q_ack[$];
  rd_t  q_rd0[$];
  rd_t  q_rd1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  int owner;        // master holding a lock, -1 if none
  int run;          // cycles spent under the current lock
  int prefer;       // master that wins a tie
  bit barred [2];   // lock refused until that master drops lock
  int pred_w;
  bit pred_held;

  // ---------------- driver state ----------------
  bit          req  [2];
  bit          we   [2];
  bit          lock [2];
  bit          pend [2];
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [3:0]  mask [2];
  int          mode;
  bit          in_reset;

  task automatic model_reset();
    owner  = -1;
    run    = 0;
    prefer = 0;
    for (int n = 0; n < 2; n++) begin
      barred[n] = 1'b0;
      pend[n]   = 1'b0;
      req[n]    = 1'b0;
      lock[n]   = 1'b0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h9E37_79B9 * 32'(i + 1);
  endtask

  task automatic gen(input int n, input int sub);
    if (pend[n]) return;
    case (mode)
      0: begin
        req[n] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 5) == 0) lock[n] = ~lock[n];
        we[n] = ($urandom_range(0, 2) == 0);
      end
      1: begin
        req[n]  = 1'b1;
        lock[n] = (n == 1) && (sub >= 8);
        we[n]   = (n == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
      2: begin
        req[n]  = 1'b1;
        lock[n] = 1'b0;
        we[n]   = ($urandom_range(0, 1) == 1);
      end
      default: begin
        req[n]  = 1'b0;
        lock[n] = 1'b0;
        we[n]   = 1'b0;
      end
    endcase
    addr[n]  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    wdata[n] = $urandom;
    mask[n]  = 4'($urandom_range(0, 15));
  endtask

  task automatic apply();
    bus.m0_req   = req[0];   bus.m1_req   = req[1];
    bus.m0_we    = we[0];    bus.m1_we    = we[1];
    bus.m0_addr  = addr[0];  bus.m1_addr  = addr[1];
    bus.m0_wdata = wdata[0]; bus.m1_wdata = wdata[1];
    bus.m0_mask  = mask[0];  bus.m1_mask  = mask[1];
    bus.m0_lock  = lock[0];  bus.m1_lock  = lock[1];
  endtask

  // Decide who the rules say owns this cycle, queue expectations, advance the model.
  task automatic predict();
    int   w;
    bit   held;
    int   idx;
    acc_t a;
    rd_t  r;
    held = (owner >= 0) ? lock[owner] : 1'b0;
    w = -1;
    if (held) begin
      if (req[owner]) w = owner;
    end else if (req[0] && req[1]) w = prefer;
    else if (req[0]) w = 0;
    else if (req[1]) w = 1;
    pred_w    = w;
    pred_held = held;

    if (w >= 0) begin
      a.cyc = cyc; a.id = w[0]; a.we = we[w]; a.addr = addr[w];
      a.wdata = wdata[w]; a.mask = mask[w];
      q_ack.push_back(a);
      idx = int'(addr[w][5:2]);
      if (!we[w]) begin
        r.cyc  = cyc + 1;
        r.data = ref_mem[idx];
        if (w == 0) q_rd0.push_back(r);
        else        q_rd1.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++)
          if (mask[w][b]) ref_mem[idx][8*b +: 8] = wdata[w][8*b +: 8];
      end
      prefer = 1 - w;
    end

    for (int n = 0; n < 2; n++) if (!lock[n]) barred[n] = 1'b0;

    if (held) begin
      run++;
      if (run == MAX_LOCK) begin
        barred[owner] = 1'b1;
        prefer = 1 - owner;
        owner  = -1;
        run    = 0;
      end
    end else begin
      owner = -1;
      run   = 0;
      if (w >= 0 && lock[w] && !barred[w]) begin
        if (MAX_LOCK == 1) barred[w] = 1'b1;
        else begin
          owner = w;
          run   = 1;
        end
      end
    end

    for (int n = 0; n < 2; n++) pend[n] = req[n] && (w != n);
  endtask

  task automatic step(input int sub);
    gen(0, sub);
    gen(1, sub);
    apply();
    predict();
  endtask

  // ---------------- monitor ----------------
  acc_t       mon_e;
  rd_t        mon_rd;
  bit         mon_have;
  bit         mon_r;
  logic [1:0] mon_exp;

  // Compare the port against the oldest expectation for this cycle.
  always @(negedge clk) begin
    if (!in_reset) begin
      mon_have = (q_ack.size() > 0) && (q_ack[0].cyc == cyc);
      if (mon_have) mon_e = q_ack.pop_front();
      mon_exp = mon_have ? (mon_e.id ? 2'b10 : 2'b01) : 2'b00;
      check("ack", {62'd0, bus.m1_ack, bus.m0_ack}, {62'd0, mon_exp});
      if (mon_have) begin
        check("mem_a",    bus.mem_a,    mon_e.addr);
        check("mem_we",   bus.mem_we,   mon_e.we);
        check("mem_mask", bus.mem_mask, mon_e.mask);
        check("mem_di",   bus.mem_di,   mon_e.wdata);
      end else begin
        check("mem_we_idle", bus.mem_we, 1'b0);
      end

      mon_r = (q_rd0.size() > 0) && (q_rd0[0].cyc == cyc);
      if (mon_r) mon_rd = q_rd0.pop_front();
      check("m0_rvalid", bus.m0_rvalid, mon_r);
      if (mon_r) check("m0_rdata", bus.m0_rdata, mon_rd.data);

      mon_r = (q_rd1.size() > 0) && (q_rd1[0].cyc == cyc);
      if (mon_r) mon_rd = q_rd1.pop_front();
      check("m1_rvalid", bus.m1_rvalid, mon_r);
      if (mon_r) check("m1_rdata", bus.m1_rdata, mon_rd.data);
    end
  end

  // ---------------- main sequence ----------------
  bit found;

  initial begin
    rst      = 1'b1;
    in_reset = 1'b1;
    mode     = 3;
    for (int n = 0; n < 2; n++) begin
      we[n] = 1'b0; addr[n] = '0; wdata[n] = '0; mask[n] = '0;
    end
    model_reset();
    apply();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("rst_m0_rdata",  bus.m0_rdata,  32'd0);
    check("rst_m1_rdata",  bus.m1_rdata,  32'd0);
    check("rst_acks",      {bus.m1_ack, bus.m0_ack}, 2'b00);
    rst      = 1'b0;
    in_reset = 1'b0;

    // First cycle out of reset with both requesting: m0 must win.
    mode = 2;
    @(posedge clk); #1; step(0);

    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1; step(i);
    end

    // Steer m1 into a held lock doing reads, then reset in the middle of it.
    mode  = 1;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk); #1; step(i);
      if (pred_held && pred_w == 1 && !we[1]) found = 1'b1;
    end
    check("lock1_read_reached", found, 1'b1);

    #2;
    rst      = 1'b1;
    in_reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      req[n]  = 1'b0;
      lock[n] = 1'b0;
    end
    apply();
    q_ack.delete();
    q_rd0.delete();
    q_rd1.delete();
    #1;
    check("arst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("arst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("arst_m0_rdata",  bus.m0_rdata,  32'd0);
    check("arst_m1_rdata",  bus.m1_rdata,  32'd0);
    check("arst_acks",      {bus.m1_ack, bus.m0_ack}, 2'b00);
    @(posedge clk); #1;
    check("arst_rvalid_dropped", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    rst = 1'b0;
    model_reset();
    in_reset = 1'b0;

    mode = 2;
    step(0);

    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1; step(i);
    end

    mode = 3;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; step(i);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
